// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_X0 = 0;

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_MEMWAIT
  } state_t;

  typedef logic [1:0] stall_cnt_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard sequencer: ID/EX/MEM status in, stage enables and counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_AW = pipe_ctrl_pkg::REG_AW
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs2;
  logic              id_is_branch;
  logic              id_br_taken;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              mem_req;
  logic              mem_ready;

  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              pc_sel_branch;
  logic              id_ex_bubble;
  logic              ex_mem_write;
  logic              mem_wb_bubble;
  logic              mem_err;
  logic [31:0]       perf_stall;
  logic [31:0]       perf_flush;
  logic [31:0]       perf_memwait;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs2, id_is_branch, id_br_taken,
           ex_rd, ex_reg_write, ex_mem_read, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, pc_sel_branch, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, mem_err, perf_stall, perf_flush, perf_memwait
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_is_branch, id_br_taken,
           ex_rd, ex_reg_write, ex_mem_read, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, pc_sel_branch, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, mem_err, perf_stall, perf_flush, perf_memwait
  );
endinterface

// File: rtl/hazard_cmp.sv
// Combinational EX-rd vs ID-rs comparison and stall-count decode for the instruction in ID.
module hazard_cmp #(
  parameter int unsigned REG_AW = 5
) (
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs1,
  input  logic [REG_AW-1:0]        id_rs2,
  input  logic                     id_uses_rs2,
  input  logic                     id_is_branch,
  input  logic [REG_AW-1:0]        ex_rd,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  output pipe_ctrl_pkg::stall_cnt_t stall_req
);
  import pipe_ctrl_pkg::*;

  logic rd_match;

  always_comb begin
    rd_match = (ex_rd != REG_AW'(REG_X0)) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    stall_req = '0;
    if (id_valid && rd_match) begin
      if (ex_mem_read)
        stall_req = id_is_branch ? stall_cnt_t'(2) : stall_cnt_t'(1);
      // ALU results are forwarded to EX, but the ID-stage comparator needs them one cycle sooner
      else if (ex_reg_write && id_is_branch)
        stall_req = stall_cnt_t'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use / branch-operand stalls, taken-branch redirect, dmem-wait freeze.
// Define HAZ_PERF_EN to build the stall/flush/memwait event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);
  import pipe_ctrl_pkg::*;

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  typedef logic [WAIT_W-1:0] wait_cnt_t;
  localparam wait_cnt_t WAIT_MAX = wait_cnt_t'(MEM_TIMEOUT);

  state_t     state, ret_state, eff_state;
  stall_cnt_t stall_cnt, haz_cnt;
  wait_cnt_t  wait_cnt;
  logic       mem_err_q;
  logic       timeout, freeze, run_hazard, stall, redirect;

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
    .id_valid     (hz.id_valid),
    .id_rs1       (hz.id_rs1),
    .id_rs2       (hz.id_rs2),
    .id_uses_rs2  (hz.id_uses_rs2),
    .id_is_branch (hz.id_is_branch),
    .ex_rd        (hz.ex_rd),
    .ex_reg_write (hz.ex_reg_write),
    .ex_mem_read  (hz.ex_mem_read),
    .stall_req    (haz_cnt)
  );

  // The release cycle out of S_MEMWAIT already behaves as the saved state, so the
  // paused stall sequence (or hazard check) resumes without an extra idle cycle.
  always_comb begin
    eff_state  = (state == S_MEMWAIT) ? ret_state : state;
    timeout    = (state == S_MEMWAIT) && (wait_cnt >= WAIT_MAX);
    freeze     = hz.mem_req && !hz.mem_ready && !timeout;
    run_hazard = (eff_state == S_RUN) && (haz_cnt != '0);
    stall      = !freeze && ((eff_state == S_STALL) || run_hazard);
    redirect   = !freeze && (eff_state == S_RUN) && !run_hazard &&
                 hz.id_is_branch && hz.id_br_taken;
  end

  assign hz.pc_write      = !(freeze || stall);
  assign hz.if_id_write   = !(freeze || stall);
  assign hz.if_id_flush   = redirect;
  assign hz.pc_sel_branch = redirect;
  assign hz.id_ex_bubble  = stall;
  assign hz.ex_mem_write  = !freeze;
  assign hz.mem_wb_bubble = freeze;
  assign hz.mem_err       = mem_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      ret_state <= S_RUN;
      stall_cnt <= '0;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else if (freeze) begin
      state <= S_MEMWAIT;
      if (state != S_MEMWAIT) begin
        ret_state <= state;
        wait_cnt  <= wait_cnt_t'(1);
      end else begin
        wait_cnt  <= wait_cnt + wait_cnt_t'(1);
      end
    end else begin
      wait_cnt <= '0;
      if (timeout)
        mem_err_q <= 1'b1;
      if (eff_state == S_STALL) begin
        stall_cnt <= stall_cnt - stall_cnt_t'(1);
        state     <= (stall_cnt > stall_cnt_t'(1)) ? S_STALL : S_RUN;
      end else if (run_hazard && (haz_cnt > stall_cnt_t'(1))) begin
        stall_cnt <= haz_cnt - stall_cnt_t'(1);
        state     <= S_STALL;
      end else begin
        state <= S_RUN;
      end
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_memwait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
      perf_memwait_q <= '0;
    end else begin
      if (stall)    perf_stall_q   <= perf_stall_q + 32'd1;
      if (redirect) perf_flush_q   <= perf_flush_q + 32'd1;
      if (freeze)   perf_memwait_q <= perf_memwait_q + 32'd1;
    end
  end

  assign hz.perf_stall   = perf_stall_q;
  assign hz.perf_flush   = perf_flush_q;
  assign hz.perf_memwait = perf_memwait_q;
`else
  assign hz.perf_stall   = 32'd0;
  assign hz.perf_flush   = 32'd0;
  assign hz.perf_memwait = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed RV32I hazard scenarios followed by random traffic vs a cycle model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO = 16;
  localparam logic [6:0] O_DFLT = 7'b1100010;
  localparam logic [6:0] O_STL  = 7'b0000110;
  localparam logic [6:0] O_RDR  = 7'b1111010;
  localparam logic [6:0] O_FRZ  = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_AW(5)) hz ();

  pipeline_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: remaining stalls owed, consecutive wait cycles, sticky error, event totals.
  int          stalls_left;
  int          waited;
  bit          err;
  logic [31:0] n_stall, n_flush, n_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int haz_stalls();
    bit match;
    if (!hz.id_valid) return 0;
    match = (hz.ex_rd != 0) &&
            ((hz.ex_rd == hz.id_rs1) || (hz.id_uses_rs2 && hz.ex_rd == hz.id_rs2));
    if (!match) return 0;
    if (hz.ex_mem_read) return hz.id_is_branch ? 2 : 1;
    if (hz.ex_reg_write && hz.id_is_branch) return 1;
    return 0;
  endfunction

  task automatic idle_inputs();
    hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_uses_rs2 = 0;
    hz.id_is_branch = 0; hz.id_br_taken = 0;
    hz.ex_rd = 0; hz.ex_reg_write = 0; hz.ex_mem_read = 0;
    hz.mem_req = 0; hz.mem_ready = 1;
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input bit u2, input bit br, input bit tk);
    hz.id_valid = v; hz.id_rs1 = 5'(rs1); hz.id_rs2 = 5'(rs2);
    hz.id_uses_rs2 = u2; hz.id_is_branch = br; hz.id_br_taken = tk;
  endtask

  task automatic set_ex(input int rd, input bit rw, input bit ld);
    hz.ex_rd = 5'(rd); hz.ex_reg_write = rw; hz.ex_mem_read = ld;
  endtask

  task automatic set_mem(input bit req, input bit rdy);
    hz.mem_req = req; hz.mem_ready = rdy;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_err"}, 32'(hz.mem_err), 32'(err));
`ifdef HAZ_PERF_EN
    check({tag, "_pstall"}, hz.perf_stall, n_stall);
    check({tag, "_pflush"}, hz.perf_flush, n_flush);
    check({tag, "_pwait"}, hz.perf_memwait, n_wait);
`else
    check({tag, "_perf"}, hz.perf_stall | hz.perf_flush | hz.perf_memwait, 32'd0);
`endif
  endtask

  // Called with inputs already applied, away from the clock edge; returns just after the next edge.
  task automatic cycle(input string tag);
    logic [6:0] e, o;
    int  n, nsl, nw;
    bit  to, fr, nerr;
    to = (waited >= TO);
    fr = hz.mem_req && !hz.mem_ready && !to;
    nsl = stalls_left; nw = waited; nerr = err;
    if (fr) begin
      e = O_FRZ; nw = waited + 1;
    end else begin
      nw = 0;
      if (to) nerr = 1;
      if (stalls_left > 0) begin
        e = O_STL; nsl = stalls_left - 1;
      end else begin
        n = haz_stalls();
        if (n > 0) begin e = O_STL; nsl = n - 1; end
        else if (hz.id_is_branch && hz.id_br_taken) e = O_RDR;
        else e = O_DFLT;
      end
    end
    #1;
    o = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.pc_sel_branch,
         hz.id_ex_bubble, hz.ex_mem_write, hz.mem_wb_bubble};
    check({tag, "_out"}, 32'(o), 32'(e));
    @(posedge clk);
    stalls_left = nsl; waited = nw; err = nerr;
    if (e == O_STL) n_stall++;
    if (e == O_RDR) n_flush++;
    if (e == O_FRZ) n_wait++;
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 0;
    stalls_left = 0; waited = 0; err = 0;
    n_stall = 0; n_flush = 0; n_wait = 0;
    #1;
    check_regs(tag);
    check({tag, "_out"}, 32'({hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.pc_sel_branch,
                              hz.id_ex_bubble, hz.ex_mem_write, hz.mem_wb_bubble}), 32'(O_DFLT));
    #1;
    rst_n = 1;
  endtask

  int hold;

  initial begin
    idle_inputs();
    rst_n = 1;
    #2;
    do_reset("reset");

    // lw x5 in EX, add x6,x5,x1 in ID
    set_ex(5, 1, 1); set_id(1, 5, 1, 1, 0, 0);
    cycle("t1_stall");
    set_ex(0, 0, 0);
    cycle("t1_after");

    // lw x5 in EX, beq x5,x0 taken in ID
    set_ex(5, 1, 1); set_id(1, 5, 0, 1, 1, 1);
    cycle("t2_stall1");
    set_ex(0, 0, 0);
    cycle("t2_stall2");
    cycle("t2_redirect");
    set_id(0, 0, 0, 0, 0, 0);
    cycle("t2_after");

    // ALU result feeding a branch: one stall
    set_ex(7, 1, 0); set_id(1, 3, 7, 1, 1, 0);
    cycle("t2b_alu_stall");
    set_ex(0, 0, 0); set_id(0, 0, 0, 0, 0, 0);
    cycle("t2b_after");

    // x0 destination never hazards
    set_ex(0, 1, 1); set_id(1, 0, 0, 1, 0, 0);
    cycle("t3_x0");
    set_ex(4, 1, 1); set_id(1, 1, 4, 0, 0, 0);
    cycle("t3_rs2_unused");
    idle_inputs();

    // Three freeze cycles, then release
    set_mem(1, 0);
    for (int i = 0; i < 3; i++) cycle("t4_freeze");
    set_mem(1, 1);
    cycle("t4_release");
    set_mem(0, 1);
    cycle("t4_after");

    // dmem never answers: forced release after TO freeze cycles
    set_mem(1, 0);
    for (int i = 0; i < TO + 3; i++) cycle("t5_timeout");
    set_mem(0, 1);
    cycle("t5_after");
    check("t5_sticky", 32'(hz.mem_err), 32'd1);
    do_reset("t5_reset");

    // Load-branch hazard with a dmem wait during the stall
    set_ex(5, 1, 1); set_id(1, 5, 0, 1, 1, 1);
    cycle("t6_stall1");
    set_ex(0, 0, 0); set_mem(1, 0);
    cycle("t6_freeze1");
    cycle("t6_freeze2");
    set_mem(1, 1);
    cycle("t6_stall2");
    set_mem(0, 1);
    cycle("t6_redirect");
    set_id(0, 0, 0, 0, 0, 0);
    cycle("t6_after");

    // Reset arriving mid-stall
    set_ex(5, 1, 1); set_id(1, 5, 0, 1, 1, 1);
    cycle("t6b_stall1");
    do_reset("t6b_reset");
    cycle("t6b_idle");

    // Random traffic
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      set_id($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 1));
      set_ex($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      if (hold == 0 && $urandom_range(0, 39) == 0) hold = $urandom_range(1, TO + 4);
      if (hold > 0) begin
        set_mem(1, 0);
        hold--;
      end else begin
        set_mem($urandom_range(0, 1), $urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd_reset");
        hold = 0;
      end else begin
        cycle("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
